// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the timer controller: FSM encodings, register map and
// CTRL field layout.
package timer_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_COMPARE  = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_COUNT    = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_PER_BIT    = 1;
  localparam int CTRL_IRQCLR_BIT = 2;

  // CTRL read-back layout, LSB first: enable, periodic, state, irq.
  typedef struct packed {
    logic       irq;
    logic [1:0] state;
    logic       periodic;
    logic       enable;
  } ctrl_rd_t;

endpackage

// File: rtl/timer_prescaler.sv
// Programmable clock divider: emits one tick every (prescale_i + 1) cycles
// while running; clear_i restarts the count from zero.
module timer_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [PRE_W-1:0] prescale_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  // Equality compare: if prescale drops below pre_cnt, the count wraps first.
  assign tick_o = run_i && (pre_cnt_q == prescale_i);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear_i) begin
      pre_cnt_d = '0;
    end else if (run_i) begin
      pre_cnt_d = tick_o ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: sequences an external up-counter through clear/run/hold,
// raising a sticky interrupt when the count reaches the compare value.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int PRE_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_write,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  input  logic [CNT_W-1:0]  cnt_value,
  output logic              cnt_enable,
  output logic              cnt_reset,
  output logic              irq
);

  logic [1:0]       state_q, state_d;
  logic             enable_q, enable_d;
  logic             periodic_q, periodic_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] compare_q;
  logic [PRE_W-1:0] prescale_q;

  logic     wr_acc, wr_ctrl, wr_en, wr_irqclr;
  logic     in_run, match, tick;
  ctrl_rd_t ctrl_rd;

  assign wr_acc    = cfg_valid && cfg_write && cfg_ready;
  assign wr_ctrl   = wr_acc && (cfg_addr == ADDR_CTRL);
  assign wr_en     = cfg_wdata[CTRL_EN_BIT];
  assign wr_irqclr = cfg_wdata[CTRL_IRQCLR_BIT];

  assign in_run = (state_q == ST_RUN);
  assign match  = in_run && (cnt_value == compare_q);

  timer_prescaler #(
    .PRE_W(PRE_W)
  ) u_prescaler (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (state_q == ST_CLEAR),
    .run_i     (in_run),
    .prescale_i(prescale_q),
    .tick_o    (tick)
  );

  assign cfg_ready  = (state_q != ST_CLEAR);
  assign cnt_reset  = (state_q == ST_CLEAR);
  assign cnt_enable = tick && (cnt_value != compare_q);
  assign irq        = irq_q;

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    periodic_d = periodic_q;
    irq_d      = irq_q;
    if (wr_ctrl) begin
      periodic_d = cfg_wdata[CTRL_PER_BIT];
      if (wr_irqclr) irq_d = 1'b0;
    end
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (wr_ctrl && wr_en) begin
          enable_d = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      default: begin
        // Match sets irq even over a same-cycle irq_clear.
        if (match) begin
          irq_d = 1'b1;
          if (periodic_q) begin
            state_d = ST_CLEAR;
          end else begin
            state_d  = ST_HOLD;
            enable_d = 1'b0;
          end
        end
      end
    endcase
    // Disable overrides everything, including a coincident match.
    if (wr_ctrl && !wr_en) begin
      state_d  = ST_IDLE;
      enable_d = 1'b0;
      irq_d    = irq_q && !wr_irqclr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      enable_q   <= 1'b0;
      periodic_q <= 1'b0;
      irq_q      <= 1'b0;
      compare_q  <= '0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      periodic_q <= periodic_d;
      irq_q      <= irq_d;
      if (wr_acc && (cfg_addr == ADDR_COMPARE))  compare_q  <= cfg_wdata[CNT_W-1:0];
      if (wr_acc && (cfg_addr == ADDR_PRESCALE)) prescale_q <= cfg_wdata[PRE_W-1:0];
    end
  end

  assign ctrl_rd = '{irq: irq_q, state: state_q, periodic: periodic_q, enable: enable_q};

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_CTRL:     cfg_rdata[4:0]       = ctrl_rd;
      ADDR_COMPARE:  cfg_rdata[CNT_W-1:0] = compare_q;
      ADDR_PRESCALE: cfg_rdata[PRE_W-1:0] = prescale_q;
      default:       cfg_rdata[CNT_W-1:0] = cnt_value;
    endcase
  end

endmodule
